// File: rtl/spec_add_pipe.sv
// Speculative block-carry adder with valid/ready handshake and a correction cycle on misprediction.
// Optional SPEC_ADD_ERRCNT_EN adds a saturating 16-bit count of correction cycles on port ErrCnt.
module spec_add_pipe #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Err
`ifdef SPEC_ADD_ERRCNT_EN
  ,
  output logic [15:0]      ErrCnt
`endif
);

  localparam int NB = WIDTH / BLK;

  typedef enum logic [1:0] {IDLE, SPEC, CORR, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] g_r, p_r;
  logic             cin_r;
  logic             accept;

  logic [NB-1:0]    blk_g, blk_p, spec_c, exact_c;
  logic [NB:0]      pre_g, pre_p;
  logic [BLK:0]     t;
  logic [WIDTH-1:0] spec_sum, exact_sum;
  logic             spec_cout, exact_cout, mismatch;

  // Ripple add of one block from its G/P bits; returns {carry_out, sum}.
  function automatic logic [BLK:0] blk_add(input logic [BLK-1:0] g, input logic [BLK-1:0] p,
                                           input logic c);
    logic [BLK:0] r;
    logic         cy;
    r  = '0;
    cy = c;
    for (int i = 0; i < BLK; i++) begin
      r[i] = p[i] ^ cy;
      cy   = g[i] | (p[i] & cy);
    end
    r[BLK] = cy;
    return r;
  endfunction

  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Element 0 of the prefix array is the carry in; element k+1 is block k.
  always_comb begin
    t = '0;
    for (int k = 0; k < NB; k++) begin
      t        = blk_add(g_r[k*BLK +: BLK], p_r[k*BLK +: BLK], 1'b0);
      blk_g[k] = t[BLK];
      blk_p[k] = &p_r[k*BLK +: BLK];
    end

    pre_g[0] = cin_r;
    pre_p[0] = 1'b0;
    for (int k = 0; k < NB; k++) begin
      pre_g[k+1] = blk_g[k];
      pre_p[k+1] = blk_p[k];
    end
    for (int d = 1; d <= NB; d = d * 2) begin
      for (int i = NB; i >= d; i--) begin
        pre_g[i] = pre_g[i] | (pre_p[i] & pre_g[i-d]);
        pre_p[i] = pre_p[i] & pre_p[i-d];
      end
    end

    for (int k = 0; k < NB; k++) begin
      exact_c[k] = pre_g[k];
      spec_c[k]  = (k == 0) ? cin_r : blk_g[k-1];
    end
    mismatch = (spec_c != exact_c);

    spec_sum = '0;
    for (int k = 0; k < NB; k++) begin
      t                      = blk_add(g_r[k*BLK +: BLK], p_r[k*BLK +: BLK], spec_c[k]);
      spec_sum[k*BLK +: BLK] = t[BLK-1:0];
    end
    spec_cout = t[BLK];

    exact_sum = '0;
    for (int k = 0; k < NB; k++) begin
      t                       = blk_add(g_r[k*BLK +: BLK], p_r[k*BLK +: BLK], exact_c[k]);
      exact_sum[k*BLK +: BLK] = t[BLK-1:0];
    end
    exact_cout = pre_g[NB];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      g_r       <= '0;
      p_r       <= '0;
      cin_r     <= 1'b0;
      out_valid <= 1'b0;
      S         <= '0;
      Cout      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      if (accept) begin
        g_r   <= A & B;
        p_r   <= A ^ B;
        cin_r <= Cin;
      end
      case (state)
        IDLE: if (accept) state <= SPEC;
        SPEC: begin
          if (mismatch) begin
            state <= CORR;
          end else begin
            S         <= spec_sum;
            Cout      <= spec_cout;
            Err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        CORR: begin
          S         <= exact_sum;
          Cout      <= exact_cout;
          Err       <= 1'b1;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? SPEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPEC_ADD_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ErrCnt <= '0;
    else if ((state == SPEC) && mismatch && (ErrCnt != 16'hFFFF))
      ErrCnt <= ErrCnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_spec_add_pipe.sv
// Scoreboard bench for spec_add_pipe: driver pushes hand-computed results, a negedge monitor pops and checks.
// Build with SPEC_ADD_ERRCNT_EN defined to also check the ErrCnt port.
module tb_spec_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0, B = '0;
  logic        Cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] S;
  logic        Cout, Err;
`ifdef SPEC_ADD_ERRCNT_EN
  logic [15:0] ErrCnt;
`endif

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        err;
    time         t_acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  spec_add_pipe #(.WIDTH(16), .BLK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .Err(Err)
`ifdef SPEC_ADD_ERRCNT_EN
    , .ErrCnt(ErrCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called and returns at posedge+2; t_acc is the time of the accepting edge.
  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic c,
                                input logic [15:0] es, input logic ec, input logic ee,
                                output time t_acc);
    logic acc = 1'b0;
    int   n = 0;
    exp_t e;
    A = a; B = b; Cin = c; in_valid = 1'b1;
    t_acc = 0;
    while (!acc && n < 50) begin
      #1 acc = in_ready;
      @(posedge clk);
      n++;
      if (!acc) #2;
    end
    if (!acc) begin
      check_output("accept_timeout", 32'(n), 32'd0);
      #2;
    end else begin
      t_acc   = $time;
      e.s     = es;
      e.cout  = ec;
      e.err   = ee;
      e.t_acc = t_acc;
      sb.push_back(e);
      #2;
    end
    in_valid = 1'b0;
  endtask

  // Monitor: each new result is popped and compared, including edges from accept (accept edge counted).
  initial begin
    logic fresh = 1'b1;
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (out_valid && fresh) begin
        fresh = 1'b0;
        if (sb.size() == 0) begin
          check_output("unexpected_result", {16'h0, S}, 32'hDEAD);
        end else begin
          e = sb.pop_front();
          check_output("sum", {16'h0, S}, {16'h0, e.s});
          check_output("cout", {31'h0, Cout}, {31'h0, e.cout});
          check_output("err", {31'h0, Err}, {31'h0, e.err});
          lat = int'(($time - e.t_acc + 5) / 10);
          check_output("latency", 32'(lat), e.err ? 32'd3 : 32'd2);
        end
      end
      if (!out_valid || out_ready) fresh = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    time ta, tp;
    logic [15:0] va [4], vb [4], vs [4];
    int n;

    #3;
    check_output("rst_in_ready", {31'h0, in_ready}, 32'd1);
    check_output("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check_output("rst_s", {16'h0, S}, 32'd0);
    check_output("rst_cout", {31'h0, Cout}, 32'd0);
    check_output("rst_err", {31'h0, Err}, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;

    // Single ops, each drained before the next.
    apply_stimulus(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, ta);
    apply_stimulus(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, ta);
    apply_stimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, ta);
    apply_stimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, ta);
    apply_stimulus(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b1, ta);
    apply_stimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, ta);
    apply_stimulus(16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 1'b0, ta);
    apply_stimulus(16'h00F8, 16'h0008, 1'b0, 16'h0100, 1'b0, 1'b1, ta);
    repeat (4) @(posedge clk);
    #2;

    // Back-to-back non-mispredicting ops: one accept every 2 cycles.
    va = '{16'h1234, 16'h0101, 16'h2222, 16'h7000};
    vb = '{16'h4321, 16'h1010, 16'h3333, 16'h1000};
    vs = '{16'h5555, 16'h1111, 16'h5555, 16'h8000};
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(va[i], vb[i], 1'b0, vs[i], 1'b0, 1'b0, ta);
      if (i > 0) check_output("b2b_interval", 32'(ta - tp), 32'd20);
      tp = ta;
      if (i < 3) begin
        A = va[i+1]; B = vb[i+1]; in_valid = 1'b1;
      end
    end
    repeat (4) @(posedge clk);
    #2;

    // Stalled consumer: result frozen, new operands refused until out_ready returns.
    out_ready = 1'b0;
    apply_stimulus(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, ta);
    A = 16'h0FFF; B = 16'h0001; Cin = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("hold_s", {16'h0, S}, 32'h2345);
      check_output("hold_err", {31'h0, Err}, 32'd0);
      check_output("hold_in_ready", {31'h0, in_ready}, 32'd0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    apply_stimulus(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b1, ta);
    repeat (5) @(posedge clk);
    #2;

    // Reset while in CORR discards the op and clears outputs immediately.
    apply_stimulus(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, ta);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_output("corr_rst_out_valid", {31'h0, out_valid}, 32'd0);
    check_output("corr_rst_s", {16'h0, S}, 32'd0);
    check_output("corr_rst_err", {31'h0, Err}, 32'd0);
    check_output("corr_rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check_output("post_rst_out_valid", {31'h0, out_valid}, 32'd0);
    #2;

    // Three mispredicting ops.
    apply_stimulus(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1, ta);
    apply_stimulus(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b1, ta);
    apply_stimulus(16'h00F8, 16'h0008, 1'b0, 16'h0100, 1'b0, 1'b1, ta);

    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef SPEC_ADD_ERRCNT_EN
    check_output("errcnt", {16'h0, ErrCnt}, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
